// File: rtl/wb_completion_queue.sv
// Writeback completion queue: merges ALU (A) and memory-pipe (B) completions into one
// ordered FIFO and drains one entry per cycle into the ROB under valid/ready.
module wb_completion_queue #(
  parameter int unsigned WORD_SIZE       = 32,
  parameter int unsigned INSTR_TYPE_SZ   = 4,
  parameter int unsigned ROB_ENTRY_WITDH = 6,
  parameter int unsigned DEPTH           = 8,
  localparam int unsigned PTR_W          = $clog2(DEPTH),
  localparam int unsigned CNT_W          = PTR_W + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       a_valid,
  input  logic [INSTR_TYPE_SZ-1:0]   a_instruction_type,
  input  logic [WORD_SIZE-1:0]       a_pc,
  input  logic [WORD_SIZE-1:0]       a_result,
  input  logic [ROB_ENTRY_WITDH-1:0] a_rob_id,
  input  logic                       b_valid,
  input  logic [INSTR_TYPE_SZ-1:0]   b_instruction_type,
  input  logic [WORD_SIZE-1:0]       b_pc,
  input  logic [WORD_SIZE-1:0]       b_result,
  input  logic [ROB_ENTRY_WITDH-1:0] b_rob_id,
  input  logic                       rob_ready,
  output logic                       out_valid,
  output logic [INSTR_TYPE_SZ-1:0]   out_instruction_type,
  output logic [WORD_SIZE-1:0]       out_pc,
  output logic [WORD_SIZE-1:0]       out_result,
  output logic [ROB_ENTRY_WITDH-1:0] out_rob_id,
  output logic                       stall,
  output logic [CNT_W-1:0]           count,
  output logic                       overflow
);

  typedef struct packed {
    logic [INSTR_TYPE_SZ-1:0]   itype;
    logic [WORD_SIZE-1:0]       pc;
    logic [WORD_SIZE-1:0]       result;
    logic [ROB_ENTRY_WITDH-1:0] rob_id;
  } entry_t;

  localparam logic [CNT_W:0] DepthW = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W:0] One    = (CNT_W + 1)'(1);
  localparam logic [CNT_W:0] Two    = (CNT_W + 1)'(2);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] b_slot;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             deq, acc_a, acc_b, drop;
  logic [CNT_W:0]   free;
  entry_t           head_entry;

  always_comb begin
    deq   = out_valid & rob_ready;
    // Same-cycle dequeue credit lets a full queue take one entry while draining.
    free  = DepthW - {1'b0, count_q} + (CNT_W + 1)'(deq);
    acc_a = 1'b0;
    acc_b = 1'b0;
    drop  = 1'b0;
    if (a_valid && b_valid) begin
      if (free >= Two) begin
        acc_a = 1'b1;
        acc_b = 1'b1;
      end else if (free == One) begin
        acc_a = 1'b1;
        drop  = 1'b1;
      end else begin
        drop  = 1'b1;
      end
    end else if (a_valid) begin
      if (free != '0) acc_a = 1'b1;
      else            drop  = 1'b1;
    end else if (b_valid) begin
      if (free != '0) acc_b = 1'b1;
      else            drop  = 1'b1;
    end

    b_slot     = tail_q + PTR_W'(acc_a);
    tail_d     = tail_q + PTR_W'(acc_a) + PTR_W'(acc_b);
    head_d     = head_q + PTR_W'(deq);
    count_d    = count_q + CNT_W'(acc_a) + CNT_W'(acc_b) - CNT_W'(deq);
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; validity is tracked solely by the count.
  always_ff @(posedge clk) begin
    if (acc_a) begin
      mem_q[tail_q] <= '{itype: a_instruction_type, pc: a_pc, result: a_result,
                         rob_id: a_rob_id};
    end
    if (acc_b) begin
      mem_q[b_slot] <= '{itype: b_instruction_type, pc: b_pc, result: b_result,
                         rob_id: b_rob_id};
    end
  end

  always_comb begin
    head_entry           = mem_q[head_q];
    out_valid            = (count_q != '0);
    out_instruction_type = out_valid ? head_entry.itype  : '0;
    out_pc               = out_valid ? head_entry.pc     : '0;
    out_result           = out_valid ? head_entry.result : '0;
    out_rob_id           = out_valid ? head_entry.rob_id : '0;
    // Fewer than two free slots, judged on registered count alone.
    stall                = (count_q > CNT_W'(DEPTH - 2));
    count                = count_q;
    overflow             = overflow_q;
  end

endmodule

// File: tb/tb_wb_completion_queue.sv
// Randomised and directed bench for wb_completion_queue (DEPTH=4) against a queue-based
// reference model.
module tb_wb_completion_queue;

  localparam int unsigned WS = 32;
  localparam int unsigned TS = 4;
  localparam int unsigned RS = 6;
  localparam int unsigned D  = 4;

  typedef struct {
    logic [TS-1:0] t;
    logic [WS-1:0] pc;
    logic [WS-1:0] res;
    logic [RS-1:0] rob;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0, rob_ready = 1'b0;
  logic [TS-1:0] a_instruction_type = '0, b_instruction_type = '0;
  logic [WS-1:0] a_pc = '0, a_result = '0, b_pc = '0, b_result = '0;
  logic [RS-1:0] a_rob_id = '0, b_rob_id = '0;
  logic          out_valid, stall, overflow;
  logic [TS-1:0] out_instruction_type;
  logic [WS-1:0] out_pc, out_result;
  logic [RS-1:0] out_rob_id;
  logic [2:0]    count;

  int   tests = 0;
  int   failed = 0;
  ent_t mq[$];
  bit   m_ovf = 1'b0;

  wb_completion_queue #(
    .WORD_SIZE(WS), .INSTR_TYPE_SZ(TS), .ROB_ENTRY_WITDH(RS), .DEPTH(D)
  ) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_instruction_type(a_instruction_type), .a_pc(a_pc),
    .a_result(a_result), .a_rob_id(a_rob_id),
    .b_valid(b_valid), .b_instruction_type(b_instruction_type), .b_pc(b_pc),
    .b_result(b_result), .b_rob_id(b_rob_id),
    .rob_ready(rob_ready), .out_valid(out_valid),
    .out_instruction_type(out_instruction_type), .out_pc(out_pc),
    .out_result(out_result), .out_rob_id(out_rob_id),
    .stall(stall), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model's view of the queue.
  task automatic check_model();
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("count", 64'(count), 64'(mq.size()));
    chk("stall", 64'(stall), 64'((D - mq.size()) < 2));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (mq.size() != 0) begin
      chk("out_pc", 64'(out_pc), 64'(mq[0].pc));
      chk("out_result", 64'(out_result), 64'(mq[0].res));
      chk("out_type", 64'(out_instruction_type), 64'(mq[0].t));
      chk("out_rob_id", 64'(out_rob_id), 64'(mq[0].rob));
    end
  endtask

  task automatic model_step(input bit av, input ent_t ea, input bit bv, input ent_t eb,
                            input bit rr);
    int sz;
    int free;
    bit dq;
    sz   = mq.size();
    dq   = (sz != 0) && rr;
    free = D - sz + int'(dq);
    if (dq) void'(mq.pop_front());
    if (av && bv) begin
      if (free >= 2) begin
        mq.push_back(ea);
        mq.push_back(eb);
      end else if (free == 1) begin
        mq.push_back(ea);
        m_ovf = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (av || bv) begin
      if (free >= 1) mq.push_back(av ? ea : eb);
      else           m_ovf = 1'b1;
    end
  endtask

  // One clock: drive at negedge, check at negedge+1, advance the model at posedge.
  task automatic cyc(input bit av, input ent_t ea, input bit bv, input ent_t eb,
                     input bit rr);
    @(negedge clk);
    a_valid = av; a_instruction_type = ea.t; a_pc = ea.pc; a_result = ea.res;
    a_rob_id = ea.rob;
    b_valid = bv; b_instruction_type = eb.t; b_pc = eb.pc; b_result = eb.res;
    b_rob_id = eb.rob;
    rob_ready = rr;
    #1 check_model();
    @(posedge clk);
    model_step(av, ea, bv, eb, rr);
    #2;
  endtask

  function automatic ent_t mk(input logic [WS-1:0] pc, input logic [RS-1:0] rob);
    ent_t e;
    e.t = TS'(pc[3:0] ^ 4'h5);
    e.pc = pc;
    e.res = pc * 3 + 1;
    e.rob = rob;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.t = TS'($urandom);
    e.pc = $urandom;
    e.res = $urandom;
    e.rob = RS'($urandom);
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; rob_ready = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  ent_t z;

  initial begin
    z = mk('0, '0);
    do_reset();

    // 1: single push, popped the following cycle.
    cyc(1, mk(32'h10, 6'd3), 0, z, 1);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_pc", 64'(out_pc), 64'h10);
    chk("t1_rob", 64'(out_rob_id), 64'd3);
    cyc(0, z, 0, z, 1);
    chk("t1_count0", 64'(count), 64'd0);

    // 2: A and B together keep A-then-B order.
    cyc(1, mk(32'h20, 6'd4), 1, mk(32'h24, 6'd5), 0);
    chk("t2_count", 64'(count), 64'd2);
    chk("t2_head_a", 64'(out_pc), 64'h20);
    cyc(0, z, 0, z, 1);
    chk("t2_head_b", 64'(out_pc), 64'h24);
    cyc(0, z, 0, z, 1);
    chk("t2_empty", 64'(count), 64'd0);

    // 3: fill without draining; stall at count>=3.
    cyc(1, mk(32'h30, 6'd1), 1, mk(32'h34, 6'd2), 0);
    chk("t3_stall_c2", 64'(stall), 64'd0);
    cyc(1, mk(32'h38, 6'd3), 0, z, 0);
    chk("t3_stall_c3", 64'(stall), 64'd1);
    cyc(0, z, 1, mk(32'h3c, 6'd4), 0);
    chk("t3_count4", 64'(count), 64'd4);
    chk("t3_stall_c4", 64'(stall), 64'd1);
    chk("t3_ovf0", 64'(overflow), 64'd0);

    // 4: full with dequeue: A takes the freed slot, B is dropped.
    cyc(1, mk(32'h40, 6'd5), 1, mk(32'h44, 6'd6), 1);
    chk("t4_count", 64'(count), 64'd4);
    chk("t4_ovf", 64'(overflow), 64'd1);
    chk("t4_head", 64'(out_pc), 64'h34);
    cyc(0, z, 0, z, 0);
    chk("t4_ovf_sticky", 64'(overflow), 64'd1);

    // 5: pointer wrap with continuous draining.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1, mk(WS'(i), RS'(i)), 0, z, 1);
      chk("t5_pc", 64'(out_pc), 64'(i));
      chk("t5_count", 64'(count), 64'd1);
    end
    cyc(0, z, 0, z, 1);

    // 6: asynchronous reset mid-cycle with entries held.
    cyc(1, mk(32'h50, 6'd1), 1, mk(32'h54, 6'd2), 0);
    cyc(1, mk(32'h58, 6'd3), 0, z, 0);
    chk("t6_count3", 64'(count), 64'd3);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_stall", 64'(stall), 64'd0);
    mq.delete();
    m_ovf = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Random traffic: first half honours stall, second half ignores it.
    for (int i = 0; i < 1200; i++) begin
      bit av, bv, rr;
      av = ($urandom_range(0, 99) < 55);
      bv = ($urandom_range(0, 99) < 45);
      rr = ($urandom_range(0, 99) < 60);
      if (i < 600 && stall) begin
        av = 1'b0;
        bv = 1'b0;
      end
      if (i == 600) chk("rand_no_ovf_when_stall_honoured", 64'(overflow), 64'd0);
      cyc(av, rnd_ent(), bv, rnd_ent(), rr);
    end
    cyc(0, z, 0, z, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
